// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing, data width.
// Used by both the receive and transmit sides.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 39;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both preset to 1 so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames (LSB first) -> byte plus one-cycle done strobe.
// Each bit is sampled mid-cell. A low stop bit flags frame_err and parks the FSM in
// S_BREAK until the line returns high.
// Optional build macro UART_RX_PARITY_EN: adds a parity cell (8E1/8O1 by PARITY_ODD)
// and drives parity_err; without it parity_err is constant 0.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam logic [7:0] CNT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);

    logic                 rx_s;
    uart_state_e          state_q;
    logic [7:0]           cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 tick_q;
    logic                 busy_q;
    logic                 ferr_q;
    logic                 perr_q;
`ifdef UART_RX_PARITY_EN
    logic                 pbit_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Receive FSM with bit-cell counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q  <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-cell: treat as a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shreg_q[idx_q] <= rx_s;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        pbit_q  <= rx_s;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        dout_q <= shreg_q;
                        ferr_q <= ~rx_s;
                        tick_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_q <= ((^shreg_q) ^ pbit_q) != PARITY_ODD;
`endif
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_BREAK: begin
                    busy_q <= 1'b1;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = tick_q;
    assign rx_busy      = busy_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_q;

endmodule
